riscv_lsu: RTL and testbench

RISCV_LSU -- requirements
Module: riscv_lsu

---
 rtl/riscv_constants.sv | 22 ++
 rtl/riscv_lsu_align.sv | 66 ++++++
 rtl/riscv_lsu.sv | 104 ++++++++++
 tb/tb_riscv_lsu.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_constants.sv
// Shared RISC-V core constants: execute and memory op encodings, LSU state.
package riscv_constants;

    typedef enum logic [3:0] {
        EXEC_ADD, EXEC_SUB, EXEC_SLL, EXEC_SLT, EXEC_SLTU,
        EXEC_XOR, EXEC_SRL, EXEC_SRA, EXEC_OR,  EXEC_AND
    } EXEC_FUN;

    typedef enum logic [3:0] {
        MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU,
        MEM_SB, MEM_SH, MEM_SW
    } MEM_FUN;

    typedef enum logic [1:0] {
        LSU_IDLE, LSU_REQ, LSU_WAIT_RESP
    } lsu_state_e;

    function automatic logic is_store(input MEM_FUN fun);
        return (fun == MEM_SB) || (fun == MEM_SH) || (fun == MEM_SW);
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane logic for the LSU: byte enables, store replication,
// load extraction/extension and alignment check. Purely combinational.
module riscv_lsu_align
    import riscv_constants::*;
(
    input  MEM_FUN      fun,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misaligned,
    input  MEM_FUN      ld_fun,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Request side: lane pattern, replicated store data, alignment fault.
    always_comb begin
        be         = 4'b0000;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        case (fun)
            MEM_LB, MEM_LBU, MEM_SB: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
            end
            MEM_LH, MEM_LHU, MEM_SH: begin
                be         = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = lane[0];
            end
            MEM_LW, MEM_SW: begin
                be         = 4'b1111;
                misaligned = (lane != 2'b00);
            end
            default: ;
        endcase
    end

    // Response side: pick the addressed lane and extend to a full word.
    always_comb begin
        ld_byte = 8'h00;
        case (ld_lane)
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
            default: ;
        endcase
        ld_half = ld_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = 32'h0;
        case (ld_fun)
            MEM_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            MEM_LBU: ld_data = {24'h0, ld_byte};
            MEM_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            MEM_LHU: ld_data = {16'h0, ld_half};
            MEM_LW:  ld_data = mem_rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one outstanding op, req/gnt then rvalid data bus.
module riscv_lsu
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  MEM_FUN                 mem_fun,
    input  logic [WORD_LENGTH-1:0] addr,
    input  logic [WORD_LENGTH-1:0] wdata,
    output logic                   stall,
    output logic                   done,
    output logic [WORD_LENGTH-1:0] rdata,
    output logic                   misaligned,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [3:0]             mem_be,
    output logic [31:0]            mem_wdata,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [31:0]            mem_rdata
);

    lsu_state_e  state_q, state_d;
    MEM_FUN      fun_q;
    logic [1:0]  lane_q;
    logic        accept;
    logic [3:0]  be_d;
    logic [31:0] wrep_d;
    logic        mis_d;
    logic [31:0] ld_data;

    riscv_lsu_align u_align (
        .fun        (mem_fun),
        .lane       (addr[1:0]),
        .wdata      (wdata),
        .be         (be_d),
        .wdata_rep  (wrep_d),
        .misaligned (mis_d),
        .ld_fun     (fun_q),
        .ld_lane    (lane_q),
        .mem_rdata  (mem_rdata),
        .ld_data    (ld_data)
    );

    // No accept in the done cycle: the upstream op is still held there.
    assign accept = (state_q == LSU_IDLE) && !done && in_valid && (mem_fun != MEM_NONE);

    // Next state and bus strobes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE:      if (accept && !mis_d) state_d = LSU_REQ;
            LSU_REQ:       if (mem_gnt) state_d = is_store(fun_q) ? LSU_IDLE : LSU_WAIT_RESP;
            LSU_WAIT_RESP: if (mem_rvalid) state_d = LSU_IDLE;
            default:       state_d = LSU_IDLE;
        endcase
        stall   = accept || (state_q != LSU_IDLE);
        mem_req = (state_q == LSU_REQ);
        mem_we  = mem_req && is_store(fun_q);
    end

    // State, captured request fields and done/result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LSU_IDLE;
            fun_q      <= MEM_NONE;
            lane_q     <= 2'b00;
            mem_addr   <= 32'h0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'h0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            rdata      <= '0;
        end else begin
            state_q    <= state_d;
            done       <= 1'b0;
            misaligned <= 1'b0;
            if (accept) begin
                if (mis_d) begin
                    done       <= 1'b1;
                    misaligned <= 1'b1;
                    rdata      <= '0;
                end else begin
                    fun_q     <= mem_fun;
                    lane_q    <= addr[1:0];
                    mem_addr  <= {addr[31:2], 2'b00};
                    mem_be    <= be_d;
                    mem_wdata <= wrep_d;
                end
            end
            if (state_q == LSU_REQ && mem_gnt && is_store(fun_q))
                done <= 1'b1;
            if (state_q == LSU_WAIT_RESP && mem_rvalid) begin
                done  <= 1'b1;
                rdata <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed table-driven bench for riscv_lsu plus reset/idle corner sequences.
module tb_riscv_lsu;
    import riscv_constants::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    MEM_FUN      mem_fun;
    logic [31:0] addr, wdata;
    logic        stall, done, misaligned;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int passes = 0;

    riscv_lsu #(.WORD_LENGTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_fun(mem_fun),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done),
        .rdata(rdata), .misaligned(misaligned), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        MEM_FUN      fun;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;
        int          dly;
        logic        st;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] rd;
        logic        mis;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int lat;
        string tag;
        tag = $sformatf("v%0d", idx);
        in_valid = 1'b1; mem_fun = v.fun; addr = v.addr; wdata = v.wdata;
        #1;
        chk({tag, " stall@accept"}, 32'(stall), 32'd1);
        tick(); lat = 1;
        if (v.mis) begin
            chk({tag, " done"}, 32'(done), 32'd1);
            chk({tag, " misaligned"}, 32'(misaligned), 32'd1);
            chk({tag, " rdata"}, rdata, 32'h0);
            chk({tag, " no mem_req"}, 32'(mem_req), 32'd0);
            chk({tag, " stall@done"}, 32'(stall), 32'd0);
        end else begin
            chk({tag, " mem_req"}, 32'(mem_req), 32'd1);
            chk({tag, " mem_we"}, 32'(mem_we), 32'(v.st));
            chk({tag, " mem_addr"}, mem_addr, v.maddr);
            chk({tag, " mem_be"}, 32'(mem_be), 32'(v.be));
            if (v.st) chk({tag, " mem_wdata"}, mem_wdata, v.mwdata);
            for (int i = 0; i < v.dly; i++) begin
                tick(); lat++;
                chk({tag, " hold req"}, 32'(mem_req), 32'd1);
                chk({tag, " hold addr"}, mem_addr, v.maddr);
                chk({tag, " hold be"}, 32'(mem_be), 32'(v.be));
                if (v.st) chk({tag, " hold wdata"}, mem_wdata, v.mwdata);
                chk({tag, " hold stall"}, 32'(stall), 32'd1);
            end
            mem_gnt = 1'b1;
            tick(); lat++;
            mem_gnt = 1'b0;
            if (!v.st) begin
                chk({tag, " no early done"}, 32'(done), 32'd0);
                mem_rvalid = 1'b1; mem_rdata = v.rsp;
                tick(); lat++;
                mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
            end
            chk({tag, " done"}, 32'(done), 32'd1);
            chk({tag, " latency"}, 32'(lat), 32'(v.lat));
            chk({tag, " misaligned=0"}, 32'(misaligned), 32'd0);
            chk({tag, " stall@done"}, 32'(stall), 32'd0);
            if (!v.st) chk({tag, " rdata"}, rdata, v.rd);
        end
        in_valid = 1'b0; mem_fun = MEM_NONE;
        tick();
        chk({tag, " done pulse"}, 32'(done), 32'd0);
        chk({tag, " idle req"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        //           fun      addr          wdata         rsp           dly st be       maddr         mwdata        rd            mis lat
        vecs[0]  = '{MEM_SB,  32'h0000_1003, 32'h0000_00AB, 32'h0,        0, 1, 4'b1000, 32'h0000_1000, 32'hABAB_ABAB, 32'h0,        0, 2};
        vecs[1]  = '{MEM_LB,  32'h0000_2001, 32'h0,        32'h0000_8000, 0, 0, 4'b0010, 32'h0000_2000, 32'h0,        32'hFFFF_FF80, 0, 3};
        vecs[2]  = '{MEM_LBU, 32'h0000_2001, 32'h0,        32'h0000_8000, 0, 0, 4'b0010, 32'h0000_2000, 32'h0,        32'h0000_0080, 0, 3};
        vecs[3]  = '{MEM_LH,  32'h0000_3002, 32'h0,        32'h8001_0000, 0, 0, 4'b1100, 32'h0000_3000, 32'h0,        32'hFFFF_8001, 0, 3};
        vecs[4]  = '{MEM_LHU, 32'h0000_3002, 32'h0,        32'h8001_0000, 0, 0, 4'b1100, 32'h0000_3000, 32'h0,        32'h0000_8001, 0, 3};
        vecs[5]  = '{MEM_LW,  32'h0000_4002, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        1, 1};
        vecs[6]  = '{MEM_SW,  32'h0000_5000, 32'h1234_5678, 32'h0,        5, 1, 4'b1111, 32'h0000_5000, 32'h1234_5678, 32'h0,        0, 7};
        vecs[7]  = '{MEM_SH,  32'h0000_6002, 32'hBEEF_1234, 32'h0,        0, 1, 4'b1100, 32'h0000_6000, 32'h1234_1234, 32'h0,        0, 2};
        vecs[8]  = '{MEM_LH,  32'h0000_3001, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        1, 1};
        vecs[9]  = '{MEM_SB,  32'h0000_1000, 32'h0000_005A, 32'h0,        1, 1, 4'b0001, 32'h0000_1000, 32'h5A5A_5A5A, 32'h0,        0, 3};
        vecs[10] = '{MEM_LB,  32'h0000_2002, 32'h0,        32'h007F_0000, 0, 0, 4'b0100, 32'h0000_2000, 32'h0,        32'h0000_007F, 0, 3};
        vecs[11] = '{MEM_SH,  32'h0000_6001, 32'h0000_1111, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        1, 1};
        vecs[12] = '{MEM_LW,  32'h0000_7000, 32'h0,        32'hDEAD_BEEF, 2, 0, 4'b1111, 32'h0000_7000, 32'h0,        32'hDEAD_BEEF, 0, 5};

        rst = 1'b1; in_valid = 1'b0; mem_fun = MEM_NONE; addr = 32'h0; wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset done", 32'(done), 32'd0);
        chk("reset misaligned", 32'(misaligned), 32'd0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset mem_be", 32'(mem_be), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);

        for (int i = 0; i < 13; i++) run_op(i, vecs[i]);

        // MEM_NONE with in_valid is not an op: no stall, no request.
        in_valid = 1'b1; mem_fun = MEM_NONE; addr = 32'h0000_8000;
        #1 chk("none stall", 32'(stall), 32'd0);
        tick();
        chk("none mem_req", 32'(mem_req), 32'd0);
        chk("none done", 32'(done), 32'd0);
        in_valid = 1'b0;

        // Reset while waiting for a load response; the late rvalid is dropped.
        in_valid = 1'b1; mem_fun = MEM_LW; addr = 32'h0000_9000;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("rst-seq in wait", 32'(stall), 32'd1);
        chk("rst-seq req low in wait", 32'(mem_req), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; mem_fun = MEM_NONE;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        chk("rst-seq done", 32'(done), 32'd0);
        chk("rst-seq stall", 32'(stall), 32'd0);
        chk("rst-seq mem_req", 32'(mem_req), 32'd0);
        chk("rst-seq mem_we", 32'(mem_we), 32'd0);
        chk("rst-seq mem_be", 32'(mem_be), 32'd0);
        chk("rst-seq mem_addr", mem_addr, 32'h0);
        chk("rst-seq mem_wdata", mem_wdata, 32'h0);
        chk("rst-seq rdata", rdata, 32'h0);
        chk("rst-seq misaligned", 32'(misaligned), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
